// File: rtl/data_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_lsu
// Description : RV64 load/store unit driving a 64-bit DATA_MEMORY port.
//               Sub-doubleword stores are read-modify-write. Optional macro
//               LSU_MISALIGN_CHK_EN turns misaligned accesses into errors.
// Revision    : 1.0  initial release
// ============================================================================
module data_mem_lsu #(
    parameter int N            = 64,
    parameter int ADDRESS_SIZE = 10,
    parameter int MEM_RD_LAT   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [2:0]              req_funct3,
    input  logic [N-1:0]            req_addr,
    input  logic [N-1:0]            req_wdata,
    output logic                    resp_valid,
    output logic [N-1:0]            resp_rdata,
    output logic                    resp_err,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDRESS_SIZE-1:0] rd_addr,
    output logic [ADDRESS_SIZE-1:0] wr_addr,
    output logic [N-1:0]            data_in,
    input  logic [N-1:0]            data_out
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_RWAIT = 3'd2,
        S_WR    = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [2:0] c_LAT_M1 = 3'(MEM_RD_LAT - 1);

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_we;
    logic [2:0]              r_funct3;
    logic [2:0]              r_off;
    logic [N-1:0]            r_wdata;
    logic [2:0]              r_cnt;

    logic [2:0]              w_off;
    logic [2:0]              w_size_mask;
    logic [2:0]              w_off_al;
    logic                    w_bad_f3;
    logic                    w_misal;
    logic                    w_err;
    logic                    w_accept;
    logic                    w_is_sd;
    logic [ADDRESS_SIZE-1:0] w_idx;
    logic [5:0]              w_shamt;
    logic [N-1:0]            w_shifted;
    logic [N-1:0]            w_load;
    logic [N-1:0]            w_mask_lo;
    logic [N-1:0]            w_mask;
    logic [N-1:0]            w_merged;
    logic                    w_unused_addr;

    // ------------------------------------------------------------------
    // Request decode (evaluated on the raw request while idle)
    // ------------------------------------------------------------------
    assign w_off         = req_addr[2:0];
    assign w_idx         = req_addr[ADDRESS_SIZE+2:3];
    assign w_unused_addr = ^req_addr[N-1:ADDRESS_SIZE+3];
    assign w_accept      = req_valid && (r_state == S_IDLE);
    assign w_is_sd       = req_we && (req_funct3 == 3'b011);
    assign w_bad_f3      = req_we ? req_funct3[2] : (req_funct3 == 3'b111);
    assign w_misal       = |(w_off & w_size_mask);

    always_comb begin
        w_size_mask = 3'b000;
        case (req_funct3[1:0])
            2'b00:   w_size_mask = 3'b000;
            2'b01:   w_size_mask = 3'b001;
            2'b10:   w_size_mask = 3'b011;
            default: w_size_mask = 3'b111;
        endcase
    end

`ifdef LSU_MISALIGN_CHK_EN
    assign w_err    = w_bad_f3 | w_misal;
    assign w_off_al = w_off;
`else
    assign w_err    = w_bad_f3;
    assign w_off_al = w_off & ~w_size_mask;
`endif

    // ------------------------------------------------------------------
    // Load extraction and store merge from the sampled memory word
    // ------------------------------------------------------------------
    assign w_shamt   = {r_off, 3'b000};
    assign w_shifted = data_out >> w_shamt;

    always_comb begin
        w_load = '0;
        case (r_funct3)
            3'b000:  w_load = {{(N-8){w_shifted[7]}},   w_shifted[7:0]};
            3'b001:  w_load = {{(N-16){w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load = {{(N-32){w_shifted[31]}}, w_shifted[31:0]};
            3'b011:  w_load = w_shifted;
            3'b100:  w_load = {{(N-8){1'b0}},  w_shifted[7:0]};
            3'b101:  w_load = {{(N-16){1'b0}}, w_shifted[15:0]};
            3'b110:  w_load = {{(N-32){1'b0}}, w_shifted[31:0]};
            default: w_load = '0;
        endcase
    end

    always_comb begin
        w_mask_lo = '0;
        case (r_funct3[1:0])
            2'b00:   w_mask_lo = {{(N-8){1'b0}},  8'hFF};
            2'b01:   w_mask_lo = {{(N-16){1'b0}}, 16'hFFFF};
            2'b10:   w_mask_lo = {{(N-32){1'b0}}, 32'hFFFF_FFFF};
            default: w_mask_lo = '1;
        endcase
    end

    assign w_mask   = w_mask_lo << w_shamt;
    assign w_merged = (data_out & ~w_mask) | ((r_wdata << w_shamt) & w_mask);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_err)        w_next = S_RESP;
                    else if (w_is_sd) w_next = S_WR;
                    else              w_next = S_RD;
                end
            end
            S_RD:    w_next = S_RWAIT;
            S_RWAIT: begin
                if (r_cnt == 3'd0) w_next = r_we ? S_WR : S_RESP;
            end
            S_WR:    w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign req_ready  = (r_state == S_IDLE);
    assign mem_read   = (r_state == S_RD);
    assign mem_write  = (r_state == S_WR);
    assign resp_valid = (r_state == S_RESP);

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_funct3   <= 3'b000;
            r_off      <= 3'b000;
            r_wdata    <= '0;
            r_cnt      <= 3'd0;
            rd_addr    <= '0;
            wr_addr    <= '0;
            data_in    <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_off    <= w_off_al;
                        r_wdata  <= req_wdata;
                        if (w_err) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (w_is_sd) begin
                            wr_addr <= w_idx;
                            data_in <= req_wdata;
                        end else begin
                            rd_addr <= w_idx;
                        end
                    end
                end
                S_RD: r_cnt <= c_LAT_M1;
                S_RWAIT: begin
                    if (r_cnt == 3'd0) begin
                        if (r_we) begin
                            // RMW targets the doubleword just read
                            wr_addr <= rd_addr;
                            data_in <= w_merged;
                        end else begin
                            resp_rdata <= w_load;
                            resp_err   <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_WR: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_lsu
// Description : Directed self-checking bench for data_mem_lsu (latency 1 and 3).
// Revision    : 1.0  initial release
// ============================================================================
module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // instance A: MEM_RD_LAT = 1
    logic        req_valid, req_ready, req_we, resp_valid, resp_err, mem_read, mem_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr, req_wdata, resp_rdata, data_in, data_out;
    logic [9:0]  rd_addr, wr_addr;

    // instance B: MEM_RD_LAT = 3
    logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_err, b_mem_read, b_mem_write;
    logic [2:0]  b_req_funct3;
    logic [63:0] b_req_addr, b_req_wdata, b_resp_rdata, b_data_in, b_data_out;
    logic [9:0]  b_rd_addr, b_wr_addr;

    int checks = 0;
    int errors = 0;

    data_mem_lsu #(.N(64), .ADDRESS_SIZE(10), .MEM_RD_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .rd_addr(rd_addr),
        .wr_addr(wr_addr), .data_in(data_in), .data_out(data_out)
    );

    data_mem_lsu #(.N(64), .ADDRESS_SIZE(10), .MEM_RD_LAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
        .mem_read(b_mem_read), .mem_write(b_mem_write), .rd_addr(b_rd_addr),
        .wr_addr(b_wr_addr), .data_in(b_data_in), .data_out(b_data_out)
    );

    // memory A: real storage, data one cycle after the read strobe
    logic [63:0] mem_a [0:1023];
    always @(posedge clk) begin
        if (mem_write) mem_a[wr_addr] <= data_in;
        if (mem_read)  data_out <= mem_a[rd_addr];
    end

    // memory B: address-derived contents, data three cycles after the strobe
    logic [63:0] b_d1, b_d2, b_d3;
    always @(posedge clk) begin
        if (b_mem_read) b_d1 <= 64'hA5A5_0000_0000_0000 | {54'd0, b_rd_addr};
        b_d2 <= b_d1;
        b_d3 <= b_d2;
    end
    assign b_data_out = b_d3;

    // strobe monitors
    int          rd_cnt = 0, wr_cnt = 0, ovl_cnt = 0, b_rd_cnt = 0, b_ovl_cnt = 0;
    logic [9:0]  last_rd_addr, last_wr_addr;
    logic [63:0] last_wr_data;
    always @(negedge clk) begin
        if (mem_read) begin rd_cnt++; last_rd_addr = rd_addr; end
        if (mem_write) begin wr_cnt++; last_wr_addr = wr_addr; last_wr_data = data_in; end
        if (mem_read && mem_write) ovl_cnt++;
        if (b_mem_read) b_rd_cnt++;
        if (b_mem_read && b_mem_write) b_ovl_cnt++;
    end

    // Issue one request on instance A; lat = cycles from accept to resp_valid, -1 on timeout
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wdata, output int lat,
                          output logic [63:0] rdata, output logic err);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        lat = -1; rdata = 'x; err = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid) begin
                lat = i; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_funct3 = 3'b0; b_req_addr = '0; b_req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
        checks++; if (resp_rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
        checks++; if ({mem_read, mem_write} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {mem_read, mem_write}); end
        checks++; if ({rd_addr, wr_addr} !== 20'd0) begin errors++; $display("FAIL reset_addrs: got %h/%h expected 0/0", rd_addr, wr_addr); end
        checks++; if (data_in !== 64'd0) begin errors++; $display("FAIL reset_data_in: got %h expected 0", data_in); end
        checks++; if (b_req_ready !== 1'b1) begin errors++; $display("FAIL reset_b_ready: got %b expected 1", b_req_ready); end
    endtask

    task automatic test_sd_ld();
        int lat; logic [63:0] rd; logic er; int r0, w0;
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(1'b1, 3'b011, 64'h320, 64'h1122334455667788, lat, rd, er);
        checks++; if (lat !== 2) begin errors++; $display("FAIL sd_latency: got %0d expected 2", lat); end
        checks++; if ((wr_cnt - w0) !== 1 || (rd_cnt - r0) !== 0) begin errors++; $display("FAIL sd_strobes: got wr=%0d rd=%0d expected wr=1 rd=0", wr_cnt - w0, rd_cnt - r0); end
        checks++; if (last_wr_addr !== 10'h064) begin errors++; $display("FAIL sd_wr_addr: got %h expected 064", last_wr_addr); end
        checks++; if (last_wr_data !== 64'h1122334455667788) begin errors++; $display("FAIL sd_data_in: got %h expected 1122334455667788", last_wr_data); end
        checks++; if (er !== 1'b0 || rd !== 64'd0) begin errors++; $display("FAIL sd_resp: got err=%b rdata=%h expected err=0 rdata=0", er, rd); end
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(1'b0, 3'b011, 64'h320, 64'd0, lat, rd, er);
        checks++; if (lat !== 3) begin errors++; $display("FAIL ld_latency: got %0d expected 3", lat); end
        checks++; if (last_rd_addr !== 10'h064 || (rd_cnt - r0) !== 1 || (wr_cnt - w0) !== 0) begin errors++; $display("FAIL ld_strobes: got addr=%h rd=%0d wr=%0d expected 064/1/0", last_rd_addr, rd_cnt - r0, wr_cnt - w0); end
        checks++; if (rd !== 64'h1122334455667788 || er !== 1'b0) begin errors++; $display("FAIL ld_rdata: got %h err=%b expected 1122334455667788 err=0", rd, er); end
    endtask

    task automatic test_sb();
        int lat; logic [63:0] rd; logic er; int r0, w0;
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(1'b1, 3'b000, 64'h325, 64'hAB, lat, rd, er);
        checks++; if (lat !== 4) begin errors++; $display("FAIL sb_latency: got %0d expected 4", lat); end
        checks++; if ((rd_cnt - r0) !== 1 || (wr_cnt - w0) !== 1 || last_rd_addr !== 10'h064) begin errors++; $display("FAIL sb_strobes: got rd=%0d wr=%0d addr=%h expected 1/1/064", rd_cnt - r0, wr_cnt - w0, last_rd_addr); end
        checks++; if (last_wr_data !== 64'h1122AB4455667788 || last_wr_addr !== 10'h064) begin errors++; $display("FAIL sb_merge: got %h@%h expected 1122ab4455667788@064", last_wr_data, last_wr_addr); end
        do_req(1'b0, 3'b000, 64'h325, 64'd0, lat, rd, er);
        checks++; if (rd !== 64'hFFFFFFFFFFFFFFAB) begin errors++; $display("FAIL lb_sign: got %h expected ffffffffffffffab", rd); end
        do_req(1'b0, 3'b100, 64'h325, 64'd0, lat, rd, er);
        checks++; if (rd !== 64'h00000000000000AB) begin errors++; $display("FAIL lbu_zero: got %h expected 00000000000000ab", rd); end
    endtask

    task automatic test_half_word();
        int lat; logic [63:0] rd; logic er;
        do_req(1'b0, 3'b001, 64'h324, 64'd0, lat, rd, er);
        checks++; if (rd !== 64'hFFFFFFFFFFFFAB44) begin errors++; $display("FAIL lh_sign: got %h expected ffffffffffffab44", rd); end
        do_req(1'b0, 3'b101, 64'h324, 64'd0, lat, rd, er);
        checks++; if (rd !== 64'h000000000000AB44) begin errors++; $display("FAIL lhu_zero: got %h expected 000000000000ab44", rd); end
        do_req(1'b0, 3'b010, 64'h324, 64'd0, lat, rd, er);
        checks++; if (rd !== 64'h000000001122AB44) begin errors++; $display("FAIL lw_pos: got %h expected 000000001122ab44", rd); end
    endtask

    task automatic test_misalign();
        int lat; logic [63:0] rd; logic er; int r0;
        r0 = rd_cnt;
        do_req(1'b0, 3'b010, 64'h322, 64'd0, lat, rd, er);
`ifdef LSU_MISALIGN_CHK_EN
        checks++; if (lat !== 1 || er !== 1'b1) begin errors++; $display("FAIL misalign_err: got lat=%0d err=%b expected 1/1", lat, er); end
        checks++; if ((rd_cnt - r0) !== 0) begin errors++; $display("FAIL misalign_noread: got %0d reads expected 0", rd_cnt - r0); end
`else
        checks++; if (lat !== 3 || er !== 1'b0) begin errors++; $display("FAIL misalign_force: got lat=%0d err=%b expected 3/0", lat, er); end
        checks++; if (rd !== 64'h0000000055667788 || last_rd_addr !== 10'h064 || (rd_cnt - r0) !== 1) begin errors++; $display("FAIL misalign_data: got %h@%h expected 0000000055667788@064", rd, last_rd_addr); end
`endif
    endtask

    task automatic test_reset_rmw();
        int lat; logic [63:0] rd; logic er; int w0; logic seen;
        w0 = wr_cnt; seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 64'h325; req_wdata = 64'h5A;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rst_rmw_read: got %b expected 1", mem_read); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin errors++; $display("FAIL rst_rmw_idle: got ready=%b resp=%b expected 1/0", req_ready, resp_valid); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        checks++; if ((wr_cnt - w0) !== 0 || seen !== 1'b0) begin errors++; $display("FAIL rst_rmw_dropped: got wr=%0d resp=%b expected 0/0", wr_cnt - w0, seen); end
        do_req(1'b0, 3'b011, 64'h320, 64'd0, lat, rd, er);
        checks++; if (rd !== 64'h1122AB4455667788) begin errors++; $display("FAIL rst_rmw_mem: got %h expected 1122ab4455667788", rd); end
    endtask

    task automatic test_invalid();
        int lat; logic [63:0] rd; logic er; int r0, w0;
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(1'b0, 3'b111, 64'h320, 64'd0, lat, rd, er);
        checks++; if (lat !== 1 || er !== 1'b1 || rd !== 64'd0) begin errors++; $display("FAIL bad_load: got lat=%0d err=%b rdata=%h expected 1/1/0", lat, er, rd); end
        do_req(1'b1, 3'b100, 64'h320, 64'hFFFF, lat, rd, er);
        checks++; if (lat !== 1 || er !== 1'b1) begin errors++; $display("FAIL bad_store: got lat=%0d err=%b expected 1/1", lat, er); end
        checks++; if ((rd_cnt - r0) !== 0 || (wr_cnt - w0) !== 0) begin errors++; $display("FAIL bad_nostrobe: got rd=%0d wr=%0d expected 0/0", rd_cnt - r0, wr_cnt - w0); end
    endtask

    task automatic test_sh_sw_wrap();
        int lat; logic [63:0] rd; logic er;
        do_req(1'b1, 3'b001, 64'h322, 64'hBEEF, lat, rd, er);
        checks++; if (last_wr_data !== 64'h1122AB44BEEF7788 || lat !== 4) begin errors++; $display("FAIL sh_merge: got %h lat=%0d expected 1122ab44beef7788 lat=4", last_wr_data, lat); end
        do_req(1'b1, 3'b010, 64'h324, 64'hFFFFFFFF_DEADBEEF, lat, rd, er);
        checks++; if (last_wr_data !== 64'hDEADBEEFBEEF7788) begin errors++; $display("FAIL sw_merge: got %h expected deadbeefbeef7788", last_wr_data); end
        do_req(1'b0, 3'b011, 64'h2320, 64'd0, lat, rd, er);
        checks++; if (rd !== 64'hDEADBEEFBEEF7788 || last_rd_addr !== 10'h064) begin errors++; $display("FAIL wrap_ld: got %h@%h expected deadbeefbeef7788@064", rd, last_rd_addr); end
        checks++; if (ovl_cnt !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d expected 0", ovl_cnt); end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, busy_ready, r0; logic rdy; logic [63:0] d1, d2;
        lat1 = -1; lat2 = -1; busy_ready = 0; rdy = 1'b0; d1 = 'x; d2 = 'x; r0 = b_rd_cnt;
        @(negedge clk);
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_funct3 = 3'b011; b_req_addr = 64'h40;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            if (lat1 < 0 && b_req_ready) busy_ready++;
            if (lat1 > 0 && j == lat1 + 1) rdy = b_req_ready;
            if (lat1 > 0 && j == lat1 + 2) b_req_valid = 1'b0;
            if (b_resp_valid) begin
                if (lat1 < 0) begin
                    lat1 = j; d1 = b_resp_rdata; b_req_addr = 64'h48;
                end else begin
                    lat2 = j; d2 = b_resp_rdata;
                    break;
                end
            end
        end
        b_req_valid = 1'b0;
        checks++; if (lat1 !== 5) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 5", lat1); end
        checks++; if (busy_ready !== 0) begin errors++; $display("FAIL b2b_busy_ready: got %0d ready cycles expected 0", busy_ready); end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_resp: got %b expected 1", rdy); end
        checks++; if (lat2 !== 11) begin errors++; $display("FAIL b2b_second_resp: got %0d expected 11", lat2); end
        checks++; if (d1 !== 64'hA5A5000000000008 || d2 !== 64'hA5A5000000000009) begin errors++; $display("FAIL b2b_data: got %h/%h expected a5a5000000000008/a5a5000000000009", d1, d2); end
        checks++; if (b_ovl_cnt !== 0 || (b_rd_cnt - r0) !== 2) begin errors++; $display("FAIL b2b_strobes: got overlap=%0d reads=%0d expected 0/2", b_ovl_cnt, b_rd_cnt - r0); end
    endtask

    initial begin
        test_reset();
        test_sd_ld();
        test_sb();
        test_half_word();
        test_misalign();
        test_reset_rmw();
        test_invalid();
        test_sh_sw_wrap();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
